mem_port_initiator: RTL and testbench

//  Requestor-side agent for one port of the 4-port round-robin memory controller.
//  - Queues local read/write commands and raises req to the arbiter.
//  - Waits for ack, then drives one valid-qualified access (address/rw/wdata).
//  - Captures read data and returns a response; one instance per port (req_0..req_3).

---
 rtl/mem_port_if.sv | 24 ++
 rtl/mem_port_initiator.sv | 190 +++++++++++++++++++
 tb/tb_mem_port_initiator.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_if.sv
// Bus between one requestor port agent and the round-robin memory controller.
// req is held from request until after the access; ack is the controller's registered grant.
interface mem_port_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              req;
  logic              ack;
  logic              valid;
  logic              rw;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, valid, rw, address, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, valid, rw, address, wdata,
    output ack, rdata
  );
endinterface

// File: rtl/mem_port_initiator.sv
// Requestor-side agent for one controller port: command FIFO, req/ack/valid sequencer, response.
// Optional ack-wait timeout enabled by defining MEM_INIT_TIMEOUT_EN.
module mem_port_initiator #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 4,
  parameter int TMO_CYC = 16
) (
  input  logic              clk,
  input  logic              reset,
  // Command side: a command transfers on the rising edge where cmd_valid && cmd_ready;
  // cmd_valid may be asserted regardless of cmd_ready and fields must hold while it waits.
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rw,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [1:0]        dbg_state,
  mem_port_if.master        bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ENT_W = 1 + ADDR_W + DATA_W;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TMO_CYC < 1) begin : g_bad_param
    $error("mem_port_initiator: DEPTH must be a power of 2 >= 2 and TMO_CYC >= 1");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    XFER    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t state, state_n;

  // FIFO: pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [PTR_W:0]     wr_ptr, rd_ptr;
  logic [ENT_W-1:0]   fifo_mem [DEPTH];
  logic [ENT_W-1:0]   head;
  logic               empty, full, push, pop;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign cmd_ready = !full;
  assign push      = cmd_valid && cmd_ready;
  assign head      = fifo_mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[PTR_W-1:0]] <= {cmd_rw, cmd_addr, cmd_wdata};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  logic              req_q, req_n;
  logic              valid_q, valid_n;
  logic              rw_q, rw_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [DATA_W-1:0] wdata_q, wdata_n;
  logic              rsp_valid_q, rsp_valid_n;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_n;

`ifdef MEM_INIT_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TMO_CYC + 1) > 5) ? $clog2(TMO_CYC + 1) : 5;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_CYC - 1);
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             rsp_err_q, rsp_err_n;
`endif

  always_comb begin
    state_n     = state;
    req_n       = req_q;
    valid_n     = valid_q;
    rw_n        = rw_q;
    addr_n      = addr_q;
    wdata_n     = wdata_q;
    rsp_valid_n = 1'b0;
    rsp_rdata_n = rsp_rdata_q;
    pop         = 1'b0;
`ifdef MEM_INIT_TIMEOUT_EN
    cnt_n       = cnt_q;
    rsp_err_n   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!empty) begin
          state_n                 = REQ;
          req_n                   = 1'b1;
          {rw_n, addr_n, wdata_n} = head;
`ifdef MEM_INIT_TIMEOUT_EN
          cnt_n                   = '0;
`endif
        end
      end
      REQ: begin
        // req stays up until the access is done so the arbiter keeps this port locked.
        if (bus.ack) begin
          state_n = XFER;
          valid_n = 1'b1;
        end
`ifdef MEM_INIT_TIMEOUT_EN
        else if (cnt_q == TMO_LAST) begin
          state_n     = IDLE;
          req_n       = 1'b0;
          pop         = 1'b1;
          rsp_valid_n = 1'b1;
          rsp_err_n   = 1'b1;
          rsp_rdata_n = '0;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
`endif
      end
      XFER: begin
        state_n     = RELEASE;
        rsp_rdata_n = rw_q ? bus.rdata : '0;
        pop         = 1'b1;
        req_n       = 1'b0;
        valid_n     = 1'b0;
      end
      RELEASE: begin
        if (!bus.ack) begin
          state_n     = IDLE;
          rsp_valid_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      req_q       <= 1'b0;
      valid_q     <= 1'b0;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state       <= state_n;
      req_q       <= req_n;
      valid_q     <= valid_n;
      rw_q        <= rw_n;
      addr_q      <= addr_n;
      wdata_q     <= wdata_n;
      rsp_valid_q <= rsp_valid_n;
      rsp_rdata_q <= rsp_rdata_n;
    end
  end

`ifdef MEM_INIT_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_n;
      rsp_err_q <= rsp_err_n;
    end
  end
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign bus.req     = req_q;
  assign bus.valid   = valid_q;
  assign bus.rw      = rw_q;
  assign bus.address = addr_q;
  assign bus.wdata   = wdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign dbg_state   = state;

endmodule

// File: tb/tb_mem_port_initiator.sv
// Bench for mem_port_initiator: controller/arbiter model, command driver, response and access scoreboards.
module tb_mem_port_initiator;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  logic              clk;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_rw;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic [1:0]        dbg_state;
  logic              ack_en;

  mem_port_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_initiator #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(4), .TMO_CYC(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_rw    (cmd_rw),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .dbg_state (dbg_state),
    .bus       (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // controller model: registered grant, drops after the access; memory behind it
  logic [DATA_W-1:0] ctl_mem [256];
  logic [DATA_W-1:0] ref_mem [256];

  always @(posedge clk or negedge reset) begin
    if (!reset) bus.ack <= 1'b0;
    else        bus.ack <= ack_en && bus.req && !bus.valid;
  end

  always @(posedge clk) begin
    if (bus.valid && !bus.rw) ctl_mem[bus.address] <= bus.wdata;
  end

  assign bus.rdata = (bus.valid && bus.rw) ? ctl_mem[bus.address] : '0;

  // scoreboard
  int n_checks = 0;
  int n_fail   = 0;
  logic [DATA_W:0]            exp_q[$];
  logic [ADDR_W+DATA_W:0]     acc_q[$];
  logic [DATA_W:0]            e;
  logic [ADDR_W+DATA_W:0]     a;
  logic                       prev_valid = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset && rsp_valid) begin
      if (exp_q.size() == 0) check("rsp_unexpected", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, e[DATA_W-1:0]});
        check("rsp_err", {31'd0, rsp_err}, {31'd0, e[DATA_W]});
      end
    end
  end

  always @(negedge clk) begin
    if (reset && bus.valid) begin
      check("valid_with_ack", {31'd0, bus.ack}, 1);
      check("valid_one_cycle", {31'd0, prev_valid}, 0);
      if (acc_q.size() == 0) check("access_unexpected", 1, 0);
      else begin
        a = acc_q.pop_front();
        check("acc_rw", {31'd0, bus.rw}, {31'd0, a[ADDR_W+DATA_W]});
        check("acc_addr", {24'd0, bus.address}, {24'd0, a[ADDR_W+DATA_W-1:DATA_W]});
        check("acc_wdata", {24'd0, bus.wdata}, {24'd0, a[DATA_W-1:0]});
      end
    end
    prev_valid <= bus.valid;
  end

  // driver tasks (called at a falling edge, return at a falling edge)
  task automatic push(input logic rw, input logic [ADDR_W-1:0] addr,
                      input logic [DATA_W-1:0] wd, input logic tmo);
    int t = 0;
    cmd_valid = 1'b1;
    cmd_rw    = rw;
    cmd_addr  = addr;
    cmd_wdata = wd;
    while (!cmd_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready) check("push_timeout", 1, 0);
    else if (tmo) exp_q.push_back({1'b1, {DATA_W{1'b0}}});
    else begin
      if (rw) exp_q.push_back({1'b0, ref_mem[addr]});
      else begin
        ref_mem[addr] = wd;
        exp_q.push_back({1'b0, {DATA_W{1'b0}}});
      end
      acc_q.push_back({rw, addr, wd});
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || bus.req) && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("drain_timeout", {31'd0, (exp_q.size() != 0 || bus.req)}, 0);
  endtask

  logic [3:0] lat_tbl [6];
  int         tmo_cnt;

  initial begin
    for (int i = 0; i < 256; i++) begin
      ctl_mem[i] = '0;
      ref_mem[i] = '0;
    end
    lat_tbl[0] = 4'b0000; lat_tbl[1] = 4'b1000; lat_tbl[2] = 4'b1100;
    lat_tbl[3] = 4'b1110; lat_tbl[4] = 4'b0000; lat_tbl[5] = 4'b0001;
    reset = 1'b0; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    ack_en = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_req", {31'd0, bus.req}, 0);
    check("rst_valid", {31'd0, bus.valid}, 0);
    check("rst_bus", {15'd0, bus.rw, bus.address, bus.wdata}, 0);
    check("rst_rsp", {22'd0, rsp_valid, rsp_err, rsp_rdata}, 0);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 1);
    check("rst_state", {30'd0, dbg_state}, 0);
    reset = 1'b1;
    @(negedge clk);

    // write 0x3C to 0x10 and check the cycle-exact handshake timeline
    cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 8'h10; cmd_wdata = 8'h3C;
    ref_mem[8'h10] = 8'h3C;
    exp_q.push_back({1'b0, 8'h00});
    acc_q.push_back({1'b0, 8'h10, 8'h3C});
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      check($sformatf("latency_t%0d", k), {28'd0, bus.req, bus.ack, bus.valid, rsp_valid},
            {28'd0, lat_tbl[k]});
    end
    @(negedge clk);
    drain();

    // read back
    push(1'b1, 8'h10, 8'h00, 1'b0);
    drain();

    // fill the FIFO with ack withheld; the fifth command waits for a free entry
    ack_en = 1'b0;
    for (int i = 0; i < 4; i++) push(1'(i & 1), 8'h20 + 8'(i), 8'hA0 + 8'(i), 1'b0);
    check("full_cmd_ready", {31'd0, cmd_ready}, 0);
    fork
      push(1'b1, 8'h21, 8'h00, 1'b0);
      begin
        repeat (3) @(negedge clk);
        ack_en = 1'b1;
      end
    join
    drain();

    // ack held low: req holds, no access
    ack_en = 1'b0;
    push(1'b1, 8'h22, 8'h00, 1'b0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      check("hold_req", {31'd0, bus.req}, 1);
      check("hold_no_valid", {31'd0, bus.valid}, 0);
      @(negedge clk);
    end
    ack_en = 1'b1;
    drain();

    // random mix
    for (int i = 0; i < 12; i++) begin
      push(1'($urandom_range(0, 1)), 8'h40 + 8'($urandom_range(0, 7)),
           8'($urandom_range(0, 255)), 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain();

    // reset during the access cycle
    push(1'b1, 8'h10, 8'h00, 1'b0);
    push(1'b1, 8'h22, 8'h00, 1'b0);
    begin
      int t = 0;
      while (!bus.valid && t < 50) begin
        @(negedge clk);
        t++;
      end
      check("xfer_reached", {31'd0, bus.valid}, 1);
    end
    #2 reset = 1'b0;
    #1;
    check("mid_rst_req", {31'd0, bus.req}, 0);
    check("mid_rst_valid", {31'd0, bus.valid}, 0);
    check("mid_rst_cmd_ready", {31'd0, cmd_ready}, 1);
    check("mid_rst_state", {30'd0, dbg_state}, 0);
    exp_q.delete();
    acc_q.delete();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("post_rst_idle", {31'd0, bus.req}, 0);
    end

`ifdef MEM_INIT_TIMEOUT_EN
    // ack never comes for the first command; second one proceeds afterwards
    ack_en = 1'b0;
    push(1'b1, 8'h10, 8'h00, 1'b1);
    push(1'b1, 8'h22, 8'h00, 1'b0);
    tmo_cnt = 0;
    while (!rsp_valid && tmo_cnt < 40) begin
      if (bus.req) tmo_cnt++;
      @(negedge clk);
    end
    check("tmo_cycles", tmo_cnt, 16);
    check("tmo_req_low", {31'd0, bus.req}, 0);
    check("tmo_err", {31'd0, rsp_err}, 1);
    ack_en = 1'b1;
    @(negedge clk);
    drain();
`endif

    check("exp_q_empty", exp_q.size(), 0);
    check("acc_q_empty", acc_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
